// File: rtl/fetch_align_buffer.sv
// fetch_align_buffer
//
// Instruction-fetch stage that sits directly in front of the decompressor.
// It issues word-aligned 32-bit reads to instruction memory and queues the
// returned halfwords. Each instruction is then presented as a 32-bit window
// together with its PC. An instruction may be 16 or 32 bits long and may
// start on any halfword. A redirect flushes the queue and restarts fetch at
// a new PC. Any response still in flight for the old stream is dropped.
//
// Compile-time option:
//   FETCH_RVC_EN  defined   : compressed (16-bit) instructions are supported.
//                             The queue holds 3 halfwords and PCs are
//                             halfword-aligned.
//   FETCH_RVC_EN  undefined : 32-bit instructions only. The queue holds
//                             2 halfwords, every transfer is 4 bytes, and
//                             redirect_pc[1] is ignored.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   redirect            flush the queue and restart fetch at redirect_pc
//   redirect_pc         new PC (bit 0 ignored)
//   mem_req, mem_addr   one-cycle read request, word-aligned address
//   mem_rvalid          read data valid
//   mem_rdata           read data, little-endian halfwords
//   inst_valid          inst_out / inst_pc / inst_is_16 are valid
//   inst_ready          consumer accepts the current instruction
//   inst_out            instruction window; the oldest halfword is in [15:0]
//   inst_pc             PC of inst_out
//   inst_is_16          inst_out[1:0] != 2'b11 (compressed encoding)
module fetch_align_buffer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic        inst_is_16
);

`ifdef FETCH_RVC_EN
    localparam bit RVC_EN = 1'b1;
    localparam int DEPTH  = 3;
`else
    localparam bit RVC_EN = 1'b0;
    localparam int DEPTH  = 2;
`endif
    // Without compressed support, every PC is word-aligned.
    localparam logic [31:0] PC_MASK = RVC_EN ? ~32'h1 : ~32'h3;

    logic [15:0] hb_reg  [DEPTH];
    logic [15:0] hb_next [DEPTH];
    // Zero-padded view of the queue. Shifted reads past the end stay in range.
    logic [15:0] hb_ext  [DEPTH+2];
    logic [15:0] push_hw [2];

    logic [1:0]  count_reg, count_next;
    logic        pend_reg, discard_reg, skip_reg;
    logic [31:0] fetch_addr_reg;
    logic [31:0] inst_pc_reg;

    logic        head_is_16, issue_ok, rsp_fire, keep_rsp, xfer;
    logic [1:0]  pop_cnt, push_cnt, keep_cnt;
    logic [2:0]  count_sum;

    // ---------------- outputs: registered state only ----------------
    always_comb begin
        head_is_16 = RVC_EN && (count_reg != 2'd0) && (hb_reg[0][1:0] != 2'b11);
        inst_valid = ((count_reg >= 2'd1) && head_is_16) || (count_reg >= 2'd2);
        if (count_reg >= 2'd2) begin
            inst_out = {hb_reg[1], hb_reg[0]};
        end else if (count_reg == 2'd1) begin
            inst_out = {16'h0000, hb_reg[0]};
        end else begin
            inst_out = 32'h0000_0000;
        end
    end

    assign inst_is_16 = head_is_16;
    assign inst_pc    = inst_pc_reg;
    assign mem_addr   = fetch_addr_reg;

    // Only request when a full word is guaranteed to fit behind the survivors.
    assign issue_ok = RVC_EN ? (count_reg <= 2'd1) : (count_reg == 2'd0);
    assign mem_req  = !rst && !redirect && !pend_reg && issue_ok;

    // ---------------- queue bookkeeping ----------------
    always_comb begin
        rsp_fire   = mem_rvalid && pend_reg;
        keep_rsp   = rsp_fire && !discard_reg && !redirect;
        push_cnt   = !keep_rsp ? 2'd0 : (skip_reg ? 2'd1 : 2'd2);
        push_hw[0] = skip_reg ? mem_rdata[31:16] : mem_rdata[15:0];
        push_hw[1] = mem_rdata[31:16];
        xfer       = inst_valid && inst_ready && !redirect;
        pop_cnt    = !xfer ? 2'd0 : (head_is_16 ? 2'd1 : 2'd2);
        keep_cnt   = count_reg - pop_cnt;
        count_sum  = {1'b0, keep_cnt} + {1'b0, push_cnt};
        count_next = count_sum[1:0];
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH + 2; gi++) begin : g_ext
            if (gi < DEPTH) begin : g_live
                assign hb_ext[gi] = hb_reg[gi];
            end else begin : g_pad
                assign hb_ext[gi] = 16'h0000;
            end
        end

        // Each slot either takes a survivor shifted down by pop_cnt, or
        // takes a newly returned halfword appended after the survivors.
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            localparam logic [1:0] SLOT = 2'(gi);
            logic [15:0] slot_next;
            logic [1:0]  push_off;
            always_comb begin
                push_off  = SLOT - keep_cnt;
                slot_next = hb_reg[gi];
                if (SLOT < keep_cnt) begin
                    case (pop_cnt)
                        2'd0:    slot_next = hb_ext[gi];
                        2'd1:    slot_next = hb_ext[gi+1];
                        default: slot_next = hb_ext[gi+2];
                    endcase
                end else if ((push_off == 2'd0) && (push_cnt != 2'd0)) begin
                    slot_next = push_hw[0];
                end else if ((push_off == 2'd1) && (push_cnt == 2'd2)) begin
                    slot_next = push_hw[1];
                end
            end
            assign hb_next[gi] = slot_next;
        end
    endgenerate

    // Halfword payload. count_reg qualifies it, so it needs no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            hb_reg[i] <= hb_next[i];
        end
    end

    // ---------------- control state ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg      <= 2'd0;
            pend_reg       <= 1'b0;
            discard_reg    <= 1'b0;
            skip_reg       <= RVC_EN && RESET_PC[1];
            inst_pc_reg    <= RESET_PC & PC_MASK;
            fetch_addr_reg <= RESET_PC & ~32'h3;
        end else if (redirect) begin
            count_reg      <= 2'd0;
            inst_pc_reg    <= redirect_pc & PC_MASK;
            fetch_addr_reg <= redirect_pc & ~32'h3;
            skip_reg       <= RVC_EN && redirect_pc[1];
            // A response still owed after this cycle belongs to the old
            // stream. A response landing this cycle is dropped here and
            // needs no flag.
            pend_reg       <= pend_reg && !mem_rvalid;
            discard_reg    <= pend_reg && !mem_rvalid;
        end else begin
            count_reg <= count_next;
            if (xfer) begin
                inst_pc_reg <= inst_pc_reg + (head_is_16 ? 32'd2 : 32'd4);
            end
            if (mem_req) begin
                pend_reg       <= 1'b1;
                fetch_addr_reg <= fetch_addr_reg + 32'd4;
            end else if (rsp_fire) begin
                pend_reg <= 1'b0;
            end
            if (rsp_fire) begin
                if (discard_reg) begin
                    discard_reg <= 1'b0;
                end else if (skip_reg) begin
                    skip_reg <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_align_buffer.sv
// Testbench for fetch_align_buffer.
// The reference model is the architectural instruction stream. Starting at
// the current PC, it reads the next instruction directly from the memory
// image. Every accepted instruction must match it. Redirects set a new
// stream PC. The bench also checks the reset outputs, the first-request and
// first-instruction timing, and the single-outstanding-request rule. It
// checks that outputs hold while stalled and that a request follows a
// stale response.
module tb_fetch_align_buffer;

`ifdef FETCH_RVC_EN
    localparam bit RVC = 1'b1;
`else
    localparam bit RVC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        inst_is_16;

    always #5 clk = ~clk;

    fetch_align_buffer #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst_out   (inst_out),
        .inst_pc    (inst_pc),
        .inst_is_16 (inst_is_16)
    );

    logic [31:0] mem [256];
    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] rand_hw();
        logic [15:0] h;
        h = 16'($urandom);
        if ($urandom_range(0, 1) == 0) h[1:0] = 2'b11;
        else                           h[1:0] = 2'($urandom_range(0, 2));
        return h;
    endfunction

    function automatic logic [15:0] mem_hw(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[9:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    // memory model and reference stream state
    logic        req_active;
    logic [31:0] req_addr;
    int          req_wait;
    int          next_lat;
    logic [31:0] exp_pc;
    logic        hold_prev;
    logic [31:0] prev_pc, prev_out;
    logic        prev_16;
    logic        stale_owed, stale_now, expect_req;
    int          idle;
    bit          stop;

    initial begin
        logic [15:0] lo;
        logic        exp16;
        logic        xfer;

        for (int i = 0; i < 256; i++) mem[i] = {rand_hw(), rand_hw()};
        mem[0] = 32'h00A0_0093;
        mem[1] = 32'h0010_0113;

        rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
        mem_rvalid = 1'b0; mem_rdata = 32'h0; inst_ready = 1'b0;
        req_active = 1'b0; req_addr = 32'h0; req_wait = 0;
        exp_pc = 32'h0; hold_prev = 1'b0; prev_pc = 32'h0; prev_out = 32'h0; prev_16 = 1'b0;
        stale_owed = 1'b0; stale_now = 1'b0; expect_req = 1'b0; idle = 0; stop = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_mem_req",    {31'h0, mem_req},    32'h0);
        check_val("rst_mem_addr",   mem_addr,            32'h0);
        check_val("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
        check_val("rst_inst_out",   inst_out,            32'h0);
        check_val("rst_inst_pc",    inst_pc,             32'h0);
        check_val("rst_inst_is_16", {31'h0, inst_is_16}, 32'h0);
        rst = 1'b0;

        for (int cyc = 0; cyc < 3000 && !stop; cyc++) begin
            // ---- drive this cycle's inputs ----
            mem_rvalid = 1'b0;
            stale_now  = 1'b0;
            if (req_active) begin
                req_wait--;
                if (req_wait == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem[req_addr[9:2]];
                    req_active = 1'b0;
                    if (stale_owed) begin
                        stale_owed = 1'b0;
                        stale_now  = 1'b1;
                    end
                end
            end else if (cyc >= 12 && $urandom_range(0, 7) == 0) begin
                mem_rvalid = 1'b1;            // no request outstanding: must be ignored
                mem_rdata  = $urandom;
            end

            redirect = 1'b0;
            if (cyc == 20) begin
                redirect = 1'b1; redirect_pc = 32'h0000_0106;
            end else if (cyc == 400) begin
                redirect = 1'b1; redirect_pc = 32'hFFFF_FFFA;
            end else if (cyc >= 12 && !(cyc >= 25 && cyc <= 40) && $urandom_range(0, 31) == 0) begin
                redirect = 1'b1; redirect_pc = $urandom & 32'h0000_03FF;
            end

            if (cyc < 12)                      inst_ready = 1'b1;
            else if (cyc >= 30 && cyc <= 34)   inst_ready = 1'b0;
            else                               inst_ready = ($urandom_range(0, 3) != 0);
            next_lat = (cyc < 12) ? 1 : int'($urandom_range(1, 3));

            #1;
            // ---- observe ----
            if (cyc == 0) begin
                check_val("first_req",  {31'h0, mem_req}, 32'h1);
                check_val("first_addr", mem_addr,          32'h0);
            end
            if (cyc == 1) check_val("valid_early", {31'h0, inst_valid}, 32'h0);
            if (cyc == 2) check_val("valid_lat2",  {31'h0, inst_valid}, 32'h1);
            if (cyc == 3) begin
                check_val("second_req",  {31'h0, mem_req}, 32'h1);
                check_val("second_addr", mem_addr,          32'h4);
            end

            if (redirect) check_val("redir_noreq", {31'h0, mem_req}, 32'h0);
            if (expect_req && !redirect) check_val("req_after_stale", {31'h0, mem_req}, 32'h1);

            if (mem_req) begin
                check_val("one_outstanding", {31'h0, req_active}, 32'h0);
                check_val("addr_aligned", {30'h0, mem_addr[1:0]}, 32'h0);
                req_active = 1'b1;
                req_addr   = mem_addr;
                req_wait   = next_lat;
            end

            if (hold_prev) begin
                check_val("hold_valid", {31'h0, inst_valid}, 32'h1);
                check_val("hold_pc",    inst_pc,             prev_pc);
                check_val("hold_out",   prev_16 ? {16'h0, inst_out[15:0]} : inst_out, prev_out);
            end

            xfer = inst_valid && inst_ready && !redirect;
            if (xfer) begin
                lo    = mem_hw(exp_pc);
                exp16 = RVC && (lo[1:0] != 2'b11);
                check_val("inst_pc",    inst_pc,             exp_pc);
                check_val("inst_is_16", {31'h0, inst_is_16}, {31'h0, exp16});
                if (exp16) begin
                    check_val("inst_out16", {16'h0, inst_out[15:0]}, {16'h0, lo});
                    exp_pc = exp_pc + 32'd2;
                end else begin
                    check_val("inst_out32", inst_out, {mem_hw(exp_pc + 32'd2), lo});
                    exp_pc = exp_pc + 32'd4;
                end
                idle = 0;
            end else begin
                idle++;
            end

            hold_prev = inst_valid && !inst_ready && !redirect;
            prev_pc   = inst_pc;
            prev_16   = inst_is_16;
            prev_out  = inst_is_16 ? {16'h0, inst_out[15:0]} : inst_out;

            if (redirect) begin
                exp_pc = RVC ? (redirect_pc & ~32'h1) : (redirect_pc & ~32'h3);
                if (req_active) stale_owed = 1'b1;
                idle = 0;
            end
            expect_req = stale_now;

            if (idle > 60) begin
                check_val("liveness", 32'(idle), 32'h0);
                stop = 1'b1;
            end

            @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
